// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift/compare ops plus iterative
// shift-add multiply and restoring divide that take WIDTH cycles in BUSY.
module alu_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             div_zero,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           iop_q, iop_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 dz_q, dz_d;

  logic                 accept, iter_op, div0, last;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     iter_res;

  function automatic logic [WIDTH-1:0] alu_1c(input logic [3:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [CNT_W-1:0]   sh;
    logic               ovf, lt, eq;
    logic [WIDTH-1:0]   r;
    sh   = y[CNT_W-1:0];
    sum  = {1'b0, x} + {1'b0, y};
    diff = x - y;
    eq   = (x == y);
    // Signed less-than from the subtraction, corrected when a-b overflows
    ovf  = (x[WIDTH-1] != y[WIDTH-1]) & (diff[WIDTH-1] != x[WIDTH-1]);
    lt   = diff[WIDTH-1] ^ ovf;
    dbl  = '0;
    r    = '0;
    case (f)
      4'd0:  r = sum[WIDTH-1:0];
      4'd1:  r = diff;
      4'd2:  r = x ^ y;
      4'd3:  r = x & ~y;
      4'd4:  begin dbl = {x, x} << sh; r = dbl[2*WIDTH-1:WIDTH]; end
      4'd5:  r = x << sh;
      4'd6:  begin dbl = {x, x} >> sh; r = dbl[WIDTH-1:0]; end
      4'd7:  r = x >> sh;
      4'd8:  r = {{(WIDTH-1){1'b0}}, eq};
      4'd9:  r = {{(WIDTH-1){1'b0}}, lt};
      4'd10: r = {{(WIDTH-1){1'b0}}, lt | eq};
      4'd11: r = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);
  assign res       = res_q;
  assign div_zero  = dz_q;
  assign iter_op   = op[3] & op[2];
  assign div0      = iter_op & op[1] & (b == '0);
  assign last      = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration: acc holds {high product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!iop_q[1]) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    iter_res = iop_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    iop_d   = iop_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        acc_d = acc_step;
        if (last) begin
          state_d = S_DONE;
          res_d   = iter_res;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      iop_d = op[1:0];
      dz_d  = 1'b0;
      if (iter_op && !div0) begin
        state_d = S_BUSY;
        cnt_d   = '0;
        opnd_d  = op[1] ? b : a;
        acc_d   = {{WIDTH{1'b0}}, (op[1] ? a : b)};
      end else begin
        state_d = S_DONE;
        dz_d    = div0;
        res_d   = div0 ? (op[0] ? a : '1) : alu_1c(op, a, b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iop_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iop_q   <= iop_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

endmodule
